// File: rtl/ecc_mailbox_pkg.sv
// rtl/ecc_mailbox_pkg.sv - status word bit positions and field widths shared by the mailbox RAM
package ecc_mailbox_pkg;

  localparam int STAT_CMD_VALID_BIT = 0;
  localparam int STAT_DONE_BIT      = 1;
  localparam int STAT_OVERRUN_BIT   = 2;
  localparam int STAT_COLLISION_BIT = 3;
  localparam int STAT_FLAG_W        = 4;

  // Width of the core status field that fills the rest of the status word.
  function automatic int stat_field_w(input int data_w);
    return data_w - STAT_FLAG_W;
  endfunction

endpackage

// File: rtl/ecc_dp_ram.sv
// rtl/ecc_dp_ram.sv - two-port read-first RAM, port A wins same-address writes, out-of-range reads return 0
module ecc_dp_ram #(
  parameter int DATA  = 256,
  parameter int ADDR  = 6,
  parameter int DEPTH = 42
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_we,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_wdata,
  output logic [DATA-1:0] a_rdata,
  input  logic            b_we,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_wdata,
  output logic [DATA-1:0] b_rdata
);

  localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);

  logic [DATA-1:0] mem [DEPTH];
  logic            a_in;
  logic            b_in;

  assign a_in = {1'b0, a_addr} < DEPTH_L;
  assign b_in = {1'b0, b_addr} < DEPTH_L;

  // Port A is written last so its data is what lands on a shared address.
  always_ff @(posedge clk) begin
    if (b_we && b_in) mem[b_addr] <= b_wdata;
    if (a_we && a_in) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= a_in ? mem[a_addr] : '0;
      b_rdata <= b_in ? mem[b_addr] : '0;
    end
  end

endmodule

// File: rtl/ecc_mailbox_ram.sv
// rtl/ecc_mailbox_ram.sv - dual-port mailbox RAM with command latch and status word; ECC_MAILBOX_COLLISION_DETECT_EN adds the collision sticky
module ecc_mailbox_ram
  import ecc_mailbox_pkg::*;
#(
  parameter int DATA      = 256,
  parameter int ADDR      = 6,
  parameter int DEPTH     = 42,
  parameter int CMD_ADDR  = 1,
  parameter int STAT_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_w,
  input  logic [ADDR-1:0] a_adbus,
  input  logic [DATA-1:0] a_data_in,
  output logic [DATA-1:0] a_data_out,
  input  logic            b_w,
  input  logic [ADDR-1:0] b_adbus,
  input  logic [DATA-1:0] b_data_in,
  output logic [DATA-1:0] b_data_out,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [DATA-1:0] cmd_data,
  input  logic [DATA-1:0] status_in,
  input  logic            done_in,
  output logic            irq
);

  localparam int              SW     = stat_field_w(DATA);
  localparam logic [ADDR-1:0] CMD_A  = ADDR'(CMD_ADDR);
  localparam logic [ADDR-1:0] STAT_A = ADDR'(STAT_ADDR);

  logic [DATA-1:0]        a_ram_q;
  logic [DATA-1:0]        b_ram_q;
  logic [DATA-1:0]        stat_word;
  logic [DATA-1:0]        stat_q;
  logic [STAT_FLAG_W-1:0] stat_flags;
  logic                   a_stat_q;
  logic                   b_stat_q;
  logic                   b_we;
  logic                   a_cmd_wr;
  logic                   cmd_load;
  logic                   ovr_set;
  logic                   a_stat_rd;
  logic                   done_q;
  logic                   ovr_q;
  logic                   coll_flag;
  logic                   status_unused;

  assign b_we      = b_w && (b_adbus != CMD_A) && (b_adbus != STAT_A);
  assign a_cmd_wr  = a_w && (a_adbus == CMD_A);
  assign cmd_load  = a_cmd_wr && !cmd_valid;
  assign ovr_set   = a_cmd_wr && cmd_valid;
  assign a_stat_rd = a_adbus == STAT_A;

  ecc_dp_ram #(
    .DATA  (DATA),
    .ADDR  (ADDR),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_we    (a_w),
    .a_addr  (a_adbus),
    .a_wdata (a_data_in),
    .a_rdata (a_ram_q),
    .b_we    (b_we),
    .b_addr  (b_adbus),
    .b_wdata (b_data_in),
    .b_rdata (b_ram_q)
  );

  // A pending command is never overwritten; cmd_data only moves on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
    end else if (cmd_load) begin
      cmd_valid <= 1'b1;
      cmd_data  <= a_data_in;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  // Set terms are ORed after the clear so a same-cycle event survives the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= done_in | (done_q & ~a_stat_rd);
      ovr_q  <= ovr_set | (ovr_q & ~a_stat_rd);
    end
  end

`ifdef ECC_MAILBOX_COLLISION_DETECT_EN
  logic coll_q;
  logic coll_set;

  assign coll_set  = a_w && b_w && (a_adbus == b_adbus);
  assign coll_flag = coll_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_set | (coll_q & ~a_stat_rd);
  end
`else
  assign coll_flag = 1'b0;
`endif

  always_comb begin
    stat_flags                     = '0;
    stat_flags[STAT_CMD_VALID_BIT] = cmd_valid;
    stat_flags[STAT_DONE_BIT]      = done_q;
    stat_flags[STAT_OVERRUN_BIT]   = ovr_q;
    stat_flags[STAT_COLLISION_BIT] = coll_flag;
  end

  assign stat_word     = {status_in[SW-1:0], stat_flags};
  assign status_unused = ^status_in[DATA-1:SW];

  // The status snapshot is registered alongside the RAM read so both share latency 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q   <= '0;
      a_stat_q <= 1'b0;
      b_stat_q <= 1'b0;
    end else begin
      stat_q   <= stat_word;
      a_stat_q <= a_stat_rd;
      b_stat_q <= b_adbus == STAT_A;
    end
  end

  assign a_data_out = a_stat_q ? stat_q : a_ram_q;
  assign b_data_out = b_stat_q ? stat_q : b_ram_q;
  assign irq        = done_q;

endmodule

// File: tb/tb_ecc_mailbox_ram.sv
// tb/tb_ecc_mailbox_ram.sv - directed bench with a behavioural mailbox model and per-cycle compare
module tb_ecc_mailbox_ram;

  localparam int DATA  = 256;
  localparam int ADDR  = 6;
  localparam int DEPTH = 42;
  localparam int CMD   = 1;
  localparam int STAT  = 0;

`ifdef ECC_MAILBOX_COLLISION_DETECT_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            a_w;
  logic [ADDR-1:0] a_adbus;
  logic [DATA-1:0] a_data_in;
  logic [DATA-1:0] a_data_out;
  logic            b_w;
  logic [ADDR-1:0] b_adbus;
  logic [DATA-1:0] b_data_in;
  logic [DATA-1:0] b_data_out;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [DATA-1:0] cmd_data;
  logic [DATA-1:0] status_in;
  logic            done_in;
  logic            irq;

  ecc_mailbox_ram #(
    .DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH), .CMD_ADDR(CMD), .STAT_ADDR(STAT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_w(a_w), .a_adbus(a_adbus), .a_data_in(a_data_in), .a_data_out(a_data_out),
    .b_w(b_w), .b_adbus(b_adbus), .b_data_in(b_data_in), .b_data_out(b_data_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .status_in(status_in), .done_in(done_in), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [DATA-1:0] m_mem [DEPTH];
  logic [DATA-1:0] m_cmd;
  logic [DATA-1:0] exp_a;
  logic [DATA-1:0] exp_b;
  bit m_cv, m_done, m_ovr, m_coll;

  task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cv = 0; m_done = 0; m_ovr = 0; m_coll = 0;
    m_cmd = '0; exp_a = '0; exp_b = '0;
  endtask

  function automatic logic [DATA-1:0] model_read(input int addr, input logic [DATA-1:0] stat);
    if (addr == STAT) return stat;
    if (addr >= DEPTH) return '0;
    return m_mem[addr];
  endfunction

  // One clock of mailbox behaviour, evaluated on the inputs seen at the edge.
  task automatic model_step();
    logic [DATA-1:0] stat;
    bit rd, ovr_set, coll_set, cv_next;
    if (rst) begin
      model_reset();
      return;
    end
    stat = {status_in[DATA-5:0], COLL_EN && m_coll, m_ovr, m_done, m_cv};
    exp_a = model_read(int'(a_adbus), stat);
    exp_b = model_read(int'(b_adbus), stat);
    rd = (a_adbus == STAT);
    if (b_w && b_adbus < DEPTH && b_adbus != STAT && b_adbus != CMD) m_mem[b_adbus] = b_data_in;
    if (a_w && a_adbus < DEPTH) m_mem[a_adbus] = a_data_in;
    coll_set = a_w && b_w && (a_adbus == b_adbus);
    ovr_set = 0;
    cv_next = m_cv;
    if (m_cv && cmd_ready) cv_next = 0;
    if (a_w && a_adbus == CMD) begin
      if (m_cv) ovr_set = 1;
      else begin
        cv_next = 1;
        m_cmd = a_data_in;
      end
    end
    m_cv   = cv_next;
    m_done = done_in || (m_done && !rd);
    m_ovr  = ovr_set || (m_ovr && !rd);
    m_coll = coll_set || (m_coll && !rd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    a_w = 0; b_w = 0; a_adbus = 3; b_adbus = 4;
    a_data_in = '0; b_data_in = '0; done_in = 0; cmd_ready = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_data_out", a_data_out, exp_a);
      check("b_data_out", b_data_out, exp_b);
      check("cmd_valid", cmd_valid, m_cv);
      check("cmd_data", cmd_data, m_cmd);
      check("irq", irq, m_done);
    end
  end

  initial begin
    rst = 1;
    idle();
    status_in = {4{64'h0123_4567_89ab_cdef}};
    model_reset();
    cycle();
    cycle();
    check("rst_a_data_out", a_data_out, '0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_data", cmd_data, '0);
    check("rst_irq", irq, 0);
    rst = 0;

    for (int i = 0; i < DEPTH; i++) begin
      a_w = 1; a_adbus = ADDR'(i); a_data_in = DATA'(32'h1000 + i); cmd_ready = 1;
      cycle();
    end
    idle();
    cycle();
    chk_en = 1;

    // command handshake
    a_w = 1; a_adbus = CMD; a_data_in = 'ha5;
    cycle(); idle();
    check("cmd_set_valid", cmd_valid, 1);
    check("cmd_set_data", cmd_data, 'ha5);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("cmd_hold_valid", cmd_valid, 1);
      check("cmd_hold_data", cmd_data, 'ha5);
    end
    cmd_ready = 1;
    cycle(); idle();
    check("cmd_accept", cmd_valid, 0);

    // overrun
    a_w = 1; a_adbus = CMD; a_data_in = 'ha5;
    cycle();
    a_data_in = 'h3c;
    cycle(); idle();
    check("ovr_cmd_data", cmd_data, 'ha5);
    a_adbus = STAT;
    cycle();
    check("ovr_bit_set", a_data_out[2], 1);
    check("ovr_bit_cv", a_data_out[0], 1);
    cycle();
    check("ovr_bit_clr", a_data_out[2], 0);
    idle(); cmd_ready = 1;
    cycle(); idle();

    // done / irq
    done_in = 1;
    cycle(); idle();
    check("irq_set", irq, 1);
    a_adbus = STAT;
    cycle(); idle();
    check("irq_clr", irq, 0);
    check("done_bit_read", a_data_out[1], 1);
    done_in = 1;
    cycle(); idle();
    a_adbus = STAT; done_in = 1;
    cycle(); idle();
    check("irq_set_wins", irq, 1);
    a_adbus = STAT;
    cycle(); idle();
    check("irq_clr2", irq, 0);

    // same-address writes
    a_w = 1; a_adbus = 5; a_data_in = 'h11;
    b_w = 1; b_adbus = 5; b_data_in = 'h22;
    cycle(); idle();
    a_adbus = 5; b_adbus = 5;
    cycle(); idle();
    check("coll_a_data", a_data_out, 'h11);
    check("coll_b_data", b_data_out, 'h11);
    b_adbus = STAT;
    cycle();
    check("coll_bit", b_data_out[3], COLL_EN);
    cycle();
    check("coll_bit_b_noclr", b_data_out[3], COLL_EN);
    idle(); a_adbus = STAT;
    cycle();
    cycle(); idle();
    check("coll_bit_clr", a_data_out[3], 0);

    // out of range, reserved addresses, read-first
    a_w = 1; a_adbus = DEPTH; a_data_in = 'hdead;
    cycle(); idle();
    a_adbus = DEPTH; b_adbus = 63;
    cycle(); idle();
    check("oob_a_read", a_data_out, '0);
    check("oob_b_read", b_data_out, '0);
    b_w = 1; b_adbus = STAT; b_data_in = 'hbeef;
    cycle(); idle();
    b_adbus = STAT;
    cycle(); idle();
    check("b_stat_word", b_data_out, {status_in[DATA-5:0], 4'b0000});
    b_w = 1; b_adbus = CMD; b_data_in = 'h77;
    cycle(); idle();
    check("b_cmd_ignored", cmd_valid, 0);
    a_w = 1; a_adbus = 7; a_data_in = 'h77; b_adbus = 7;
    cycle(); idle();
    check("rdfirst_a", a_data_out, 'h1007);
    check("rdfirst_b", b_data_out, 'h1007);
    b_adbus = 7;
    cycle(); idle();
    check("rdfirst_new", b_data_out, 'h77);

    // reset mid-handshake
    done_in = 1;
    cycle(); idle();
    a_w = 1; a_adbus = CMD; a_data_in = 'h99;
    cycle(); idle();
    a_adbus = 5;
    cycle();
    check("pre_rst_cv", cmd_valid, 1);
    check("pre_rst_a", a_data_out, 'h11);
    #2;
    rst = 1;
    model_reset();
    #1;
    check("rst_now_cv", cmd_valid, 0);
    check("rst_now_cmd", cmd_data, '0);
    check("rst_now_irq", irq, 0);
    check("rst_now_a", a_data_out, '0);
    check("rst_now_b", b_data_out, '0);
    cycle();
    cycle();
    rst = 0;
    a_adbus = 5;
    cycle();
    check("mem_retained", a_data_out, 'h11);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
